// File: rtl/hpsfpga_led_pkg.sv
// Shared definitions for the HPS/FPGA LED bank arbiter.
//   LED_W   : width of the LED bank and the slide-switch bank
//   OVR_BIT : switch index that locks the HPS out of the bank
//   arb_state_e : arbiter FSM states
//   owner_e     : encoding of the "last owner" register
package hpsfpga_led_pkg;

   localparam int LED_W   = 10;
   localparam int OVR_BIT = 9;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT_HPS  = 2'd1,
      GRANT_FPGA = 2'd2,
      BLANK      = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_FPGA = 1'b0,
      OWN_HPS  = 1'b1
   } owner_e;

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: 2-flop synchronizer followed by a
// stability counter. The output only flips after the synchronized input
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks; any clock
// where they agree clears the counter.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   raw_i  : raw switch, asynchronous to clk_i
//   db_o   : debounced switch level
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic db_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts the clocks of disagreement already seen; the change is
   // accepted on the clock that completes the DEBOUNCE_CYCLES-th one.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_MAX) db_d  = sync2_q;
         else                  cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/led_bank_arbiter.sv
// Arbitrates the physical LED bank between the HPS and the local fabric.
// Grants have a minimum tenure (HOLD_CYCLES), ties alternate via a last
// owner pointer, and every handover passes through a one-clock dark BLANK
// state. Switch bit OVR_BIT locks the HPS out and evicts it immediately.
//   clk_clk       : clock
//   reset_reset_n : asynchronous active-low reset
//   sw_raw        : raw slide switches (asynchronous)
//   hps_req/led   : HPS request level and LED pattern
//   fpga_req/led  : fabric request level and LED pattern
//   led_out       : registered LED drive
//   gnt_hps/fpga  : current owner (one-hot or none)
//   sw_db         : debounced switches
module led_bank_arbiter
   import hpsfpga_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 50000000
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [LED_W-1:0] sw_raw,
   input  logic             hps_req,
   input  logic [LED_W-1:0] hps_led,
   input  logic             fpga_req,
   input  logic [LED_W-1:0] fpga_led,
   output logic [LED_W-1:0] led_out,
   output logic             gnt_hps,
   output logic             gnt_fpga,
   output logic [LED_W-1:0] sw_db
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   genvar gi;
   generate
      for (gi = 0; gi < LED_W; gi++) begin : g_db
         sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_db (
            .clk_i (clk_clk),
            .rst_ni(reset_reset_n),
            .raw_i (sw_raw[gi]),
            .db_o  (sw_db[gi])
         );
      end
   endgenerate

   arb_state_e       state_q, state_d;
   owner_e           last_q, last_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             eff_hps, hold_exp;

   assign eff_hps  = hps_req & ~sw_db[OVR_BIT];
   assign hold_exp = (hold_q == HOLD_MAX);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = '0;
      led_d   = sw_db;
      case (state_q)
         IDLE: begin
            led_d = sw_db;
            // On a tie, the requester that did not own the bank last wins.
            if (eff_hps && (!fpga_req || last_q == OWN_FPGA)) begin
               state_d = GRANT_HPS;
               last_d  = OWN_HPS;
            end else if (fpga_req) begin
               state_d = GRANT_FPGA;
               last_d  = OWN_FPGA;
            end
         end
         GRANT_HPS: begin
            led_d  = hps_led;
            hold_d = hold_exp ? hold_q : hold_q + HW'(1);
            // Override evicts the HPS regardless of remaining tenure.
            if (sw_db[OVR_BIT])
               state_d = BLANK;
            else if (hold_exp && (!eff_hps || fpga_req))
               state_d = BLANK;
         end
         GRANT_FPGA: begin
            led_d  = fpga_led;
            hold_d = hold_exp ? hold_q : hold_q + HW'(1);
            if (hold_exp && (!fpga_req || eff_hps))
               state_d = BLANK;
         end
         BLANK: begin
            led_d   = '0;
            state_d = IDLE;
         end
         default: begin
            led_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
         last_q  <= OWN_FPGA;
         hold_q  <= '0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         led_q   <= led_d;
      end
   end

   assign led_out  = led_q;
   assign gnt_hps  = (state_q == GRANT_HPS);
   assign gnt_fpga = (state_q == GRANT_FPGA);

endmodule

// File: tb/tb_led_bank_arbiter.sv
module tb_led_bank_arbiter;

   localparam logic [9:0] HLED = 10'h2AA;
   localparam logic [9:0] FLED = 10'h155;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] sw_raw = '0;
   logic       hps_req = 1'b0, fpga_req = 1'b0;
   logic [9:0] hps_led = HLED, fpga_led = FLED;
   logic [9:0] led_out, sw_db;
   logic       gnt_hps, gnt_fpga;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_bank_arbiter #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (8)
   ) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .sw_raw       (sw_raw),
      .hps_req      (hps_req),
      .hps_led      (hps_led),
      .fpga_req     (fpga_req),
      .fpga_led     (fpga_led),
      .led_out      (led_out),
      .gnt_hps      (gnt_hps),
      .gnt_fpga     (gnt_fpga),
      .sw_db        (sw_db)
   );

   // One row = inputs driven before an edge and outputs expected after it.
   typedef struct {
      bit         rst;
      logic [9:0] sw;
      logic       hr, fr;
      logic       egh, egf;
      logic [9:0] eled, edb;
   } vec_t;

   typedef struct {
      int         row;
      logic       egh, egf;
      logic [9:0] eled, edb;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input bit rst, input logic [9:0] sw, input logic hr, input logic fr,
                      input logic gh, input logic gf, input logic [9:0] led, input logic [9:0] db,
                      input int n);
      for (int k = 0; k < n; k++) begin
         vec_t v;
         v.rst = rst && (k == 0);
         v.sw = sw; v.hr = hr; v.fr = fr;
         v.egh = gh; v.egf = gf; v.eled = led; v.edb = db;
         tbl.push_back(v);
      end
   endtask

   // Reset is applied and checked away from the clock edge; returns on a
   // falling edge with reset released.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; sw_raw = '0; hps_req = 1'b0; fpga_req = 1'b0;
      #1;
      chk("rst_gnt_hps", -1, 32'(gnt_hps), 32'd0);
      chk("rst_gnt_fpga", -1, 32'(gnt_fpga), 32'd0);
      chk("rst_led", -1, 32'(led_out), 32'd0);
      chk("rst_sw_db", -1, 32'(sw_db), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Tie after reset: HPS first, then handover to FPGA after hold expiry.
      add(1, 10'h000, 1, 1, 1, 0, 10'h000, 10'h000, 1);
      add(0, 10'h000, 1, 1, 1, 0, HLED,    10'h000, 7);
      add(0, 10'h000, 1, 1, 0, 0, HLED,    10'h000, 1);  // BLANK entered
      add(0, 10'h000, 1, 1, 0, 0, 10'h000, 10'h000, 1);  // IDLE, dark LEDs
      add(0, 10'h000, 1, 1, 0, 1, 10'h000, 10'h000, 1);  // FPGA granted
      add(0, 10'h000, 1, 1, 0, 1, FLED,    10'h000, 1);
      // Debounce: held change lands 6 clocks later; 3-clock pulses rejected.
      add(1, 10'h001, 0, 0, 0, 0, 10'h000, 10'h000, 5);
      add(0, 10'h001, 0, 0, 0, 0, 10'h000, 10'h001, 1);
      add(0, 10'h003, 0, 0, 0, 0, 10'h001, 10'h001, 3);
      add(0, 10'h001, 0, 0, 0, 0, 10'h001, 10'h001, 1);
      add(0, 10'h003, 0, 0, 0, 0, 10'h001, 10'h001, 3);
      add(0, 10'h001, 0, 0, 0, 0, 10'h001, 10'h001, 5);
      // Hold: FPGA drops its request early but keeps the bank until expiry.
      add(1, 10'h00F, 0, 0, 0, 0, 10'h000, 10'h000, 5);
      add(0, 10'h00F, 0, 0, 0, 0, 10'h000, 10'h00F, 1);
      add(0, 10'h00F, 0, 0, 0, 0, 10'h00F, 10'h00F, 1);
      add(0, 10'h00F, 0, 1, 0, 1, 10'h00F, 10'h00F, 1);
      add(0, 10'h00F, 0, 1, 0, 1, FLED,    10'h00F, 1);
      add(0, 10'h00F, 0, 0, 0, 1, FLED,    10'h00F, 6);
      add(0, 10'h00F, 0, 0, 0, 0, FLED,    10'h00F, 1);
      add(0, 10'h00F, 0, 0, 0, 0, 10'h000, 10'h00F, 1);
      add(0, 10'h00F, 0, 0, 0, 0, 10'h00F, 10'h00F, 1);
      // Override: sw_db[9] rises at hold_cnt=1 and evicts the HPS at once.
      add(1, 10'h200, 0, 0, 0, 0, 10'h000, 10'h000, 4);
      add(0, 10'h200, 1, 1, 1, 0, 10'h000, 10'h000, 1);
      add(0, 10'h200, 1, 1, 1, 0, HLED,    10'h200, 1);
      add(0, 10'h200, 1, 1, 0, 0, HLED,    10'h200, 1);
      add(0, 10'h200, 1, 1, 0, 0, 10'h000, 10'h200, 1);
      add(0, 10'h200, 1, 1, 0, 1, 10'h200, 10'h200, 1);
      add(0, 10'h200, 1, 1, 0, 1, FLED,    10'h200, 4);

      for (int i = 0; i < tbl.size(); i++) begin
         exp_t e;
         if (tbl[i].rst) do_reset();
         else            @(negedge clk);
         sw_raw = tbl[i].sw; hps_req = tbl[i].hr; fpga_req = tbl[i].fr;
         e.row = i; e.egh = tbl[i].egh; e.egf = tbl[i].egf;
         e.eled = tbl[i].eled; e.edb = tbl[i].edb;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            chk("sb_empty", i, 32'd0, 32'd1);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("gnt_hps", x.row, 32'(gnt_hps), 32'(x.egh));
            chk("gnt_fpga", x.row, 32'(gnt_fpga), 32'(x.egf));
            chk("led_out", x.row, 32'(led_out), 32'(x.eled));
            chk("sw_db", x.row, 32'(sw_db), 32'(x.edb));
         end
      end

      // Reset mid-grant: everything clears without a clock, HPS wins after.
      do_reset();
      sw_raw = 10'h00F; fpga_req = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("mid_gnt_fpga", 100, 32'(gnt_fpga), 32'd1);
      chk("mid_led", 100, 32'(led_out), 32'(FLED));
      chk("mid_sw_db", 100, 32'(sw_db), 32'h00F);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_gnt_fpga", 101, 32'(gnt_fpga), 32'd0);
      chk("async_gnt_hps", 101, 32'(gnt_hps), 32'd0);
      chk("async_led", 101, 32'(led_out), 32'd0);
      chk("async_sw_db", 101, 32'(sw_db), 32'd0);
      hps_req = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_gnt_hps", 102, 32'(gnt_hps), 32'd1);
      chk("post_rst_gnt_fpga", 102, 32'(gnt_fpga), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_bank_arbiter.md
LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive stable clocks required to accept a switch change (10 ms at 50 MHz); legal range is 1 or more.
REQ-002 Parameter HOLD_CYCLES, default 50000000, SHALL set the minimum grant tenure in clocks; legal range is 1 or more.
REQ-003 clk_clk  input  1  sole clock; all state is on its rising edge.
REQ-004 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-005 sw_raw  input  10  raw slide switches; asynchronous to clk_clk.
REQ-006 hps_req  input  1  HPS requester wants the LED bank (level).
REQ-007 hps_led  input  10  HPS LED pattern, from the LED PIO export.
REQ-008 fpga_req  input  1  local fabric requester wants the LED bank (level).
REQ-009 fpga_led  input  10  local fabric LED pattern.
REQ-010 led_out  output  10  registered drive to the physical LEDs.
REQ-011 gnt_hps / gnt_fpga  output  1 each  current owner; one-hot or both 0.
REQ-012 sw_db  output  10  debounced switches, routed to the switch PIO export.

Function
REQ-013 Each switch bit SHALL pass through a 2-flop synchronizer; sw_db[i] SHALL take the synchronized value only after that value has differed from sw_db[i] for DEBOUNCE_CYCLES consecutive clocks.
REQ-014 Any glitch that returns to the current sw_db[i] value SHALL clear that bit's counter to 0.
REQ-015 The effective HPS request SHALL be eff_hps = hps_req AND NOT sw_db[9]; sw_db[9] is the local-override switch.
REQ-016 The FSM SHALL have four states: IDLE, GRANT_HPS, GRANT_FPGA and BLANK.
REQ-017 gnt_hps SHALL be 1 only in GRANT_HPS, and gnt_fpga SHALL be 1 only in GRANT_FPGA.
REQ-018 IDLE -> grant: with exactly one request, the FSM SHALL grant that requester; with both requesting, it SHALL grant the requester not in register last; with none, it SHALL stay in IDLE.
REQ-019 On entry to a GRANT state, the FSM SHALL clear hold_cnt to 0 and set last to that requester; hold_cnt SHALL increment each clock and saturate at HOLD_CYCLES-1.
REQ-020 In a GRANT state with hold_cnt < HOLD_CYCLES-1, the FSM SHALL stay in the state regardless of requests; HPS override is the exception (REQ-022).
REQ-021 In a GRANT state once hold has expired, the FSM SHALL go to BLANK if the owner drops its request or the other requester is asserting; otherwise it SHALL stay.
REQ-022 In GRANT_HPS, sw_db[9]=1 SHALL force BLANK on the next clock, ignoring hold.
REQ-023 BLANK SHALL last exactly one clock and SHALL then go to IDLE, which hands the bank over through the last pointer.
REQ-024 led_out(n+1) SHALL be:
  - sw_db in IDLE;
  - hps_led in GRANT_HPS;
  - fpga_led in GRANT_FPGA;
  - 10'h000 in BLANK;
  each evaluated on the state and inputs at cycle n.
REQ-025 Request-to-grant latency from IDLE SHALL be 1 clock; a request dropped and re-asserted within the same clock edge is not observable.
REQ-026 Handover from an expired-hold owner to a waiting requester SHALL take 3 clocks: GRANT, then BLANK, then IDLE, then the new GRANT.

Reset
REQ-027 While reset_reset_n=0, the block SHALL hold:
  - state IDLE, last = FPGA (so HPS wins the first tie);
  - hold_cnt = 0;
  - all debounce counters = 0;
  - synchronizers = 0, sw_db = 0;
  - led_out = 0, gnt_hps = 0, gnt_fpga = 0.
REQ-028 Reset asserted mid-grant or mid-debounce SHALL abort immediately, with no BLANK cycle; after release the block SHALL behave as from power-up.

Structure
REQ-029 Package hpsfpga_led_pkg SHALL hold LED_W = 10, the state enum (IDLE, GRANT_HPS, GRANT_FPGA, BLANK), and the override bit index OVR_BIT = 9.
REQ-030 A single-bit sub-module sw_debounce (synchronizer plus counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated LED_W times; the arbiter FSM SHALL stay in led_bank_arbiter.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-031 Debounce: sw_raw[0] 0->1 held -> sw_db[0]=1 exactly 2+4 clocks later; a 3-clock pulse -> sw_db stays 0.
REQ-032 Tie after reset: hps_req=fpga_req=1 at cycle 0 -> gnt_hps=1 at cycle 1, led_out=hps_led at cycle 2; at hold expiry: BLANK, led_out=0, then IDLE, then gnt_fpga=1.
REQ-033 Hold: a GRANT_FPGA owner drops fpga_req 2 clocks after grant -> gnt_fpga stays 1 until hold_cnt=7, then BLANK, then IDLE with led_out=sw_db.
REQ-034 Override: in GRANT_HPS at hold_cnt=1, sw_db[9] goes 1 with fpga_req=1 -> BLANK on the next clock, then gnt_fpga=1 2 clocks later; hps_req is ignored while sw_db[9]=1.
REQ-035 Reset mid-grant: reset_reset_n pulsed low during GRANT_FPGA -> outputs go to 0 asynchronously; after release with both requesting, HPS is granted first.
